branch_pc_unit: RTL
===================

// Module: branch_pc_unit
// PURPOSE
//  Program-counter / branch stage downstream of the flag register. Holds the PC,
//  evaluates conditional branches against the 8-bit flag word (Z=0,O=1,N=2,C=3,
//  I=4,A=5), and keeps a small hardware return-address stack for CALL/RET.
//  Its pc output feeds instruction fetch; its taken output feeds the fetch flush.
// PARAMETERS
//  ADDR_W       8      PC / target width in bits
//  STACK_DEPTH  4      return-address stack entries (>=1)
//  RESET_PC     0      PC value loaded on reset
//  IRQ_VEC      8'hF0  interrupt vector (used only with BPU_IRQ_EN)
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  reset      in   1        synchronous, active-high reset
//  en         in   1        advance enable; 0 = stall, all state held
//  instr      in   5        opcode of the instruction at the current pc
//  sel        in   3        flag selector for BRF
//  val        in   1        required flag value for BRF
//  target     in   ADDR_W   branch / jump / call target
//  flags      in   8        current flag-register output
//  irq        in   1        interrupt request (level)
//  pc         out  ADDR_W   program counter
//  taken      out  1        1-cycle pulse: previous cycle redirected the pc
//  stack_ovf  out  1        sticky: CALL/IRQ attempted with stack full
//  stack_unf  out  1        sticky: RET attempted with stack empty
//  irq_ack    out  1        1-cycle pulse: interrupt accepted
// BEHAVIOUR
//  - Reset: pc=RESET_PC, stack pointer=0 (empty), taken=0, stack_ovf=0,
//    stack_unf=0, irq_ack=0. Reset overrides en and any in-flight operation.
//  - en=0: pc, stack, stickies held; taken and irq_ack driven 0.
//  - en=1, latency 1: instr/flags/target sampled at posedge, new pc visible next.
//  - Opcodes (all others, incl. ALU ops and LDFI/MOVF): pc<=pc+1, taken=0.
//    5'h1B BRF : if sel<=5 and flags[sel]==val -> pc<=target, taken=1;
//                else pc<=pc+1. sel 6,7 reserved: never taken. sel=5,val=1 is
//                always-taken (A flag is hard 1).
//    5'h1C JMP : pc<=target, taken=1.
//    5'h1D CALL: push pc+1; pc<=target, taken=1. Stack full: no push,
//                stack_ovf<=1, jump still performed.
//    5'h1E RET : pop -> pc, taken=1. Stack empty: stack_unf<=1, pc<=pc+1,
//                taken=0.
//  - pc+1 and pushed addresses wrap modulo 2**ADDR_W (all-ones -> 0).
//  - Stack is LIFO, pointer 0..STACK_DEPTH; full when pointer==STACK_DEPTH.
//  - Stickies clear only on reset.
// CONFIGURATION
//  BPU_IRQ_EN defined: when en=1, irq=1 and flags[4]=1, interrupt takes
//    priority over instr (instr not executed): push pc (the skipped
//    instruction's address), pc<=IRQ_VEC, taken=1, irq_ack=1. Full stack:
//    stack_ovf<=1, no push, still vectors. irq with flags[4]=0 ignored.
//  BPU_IRQ_EN undefined: irq ignored, irq_ack tied 0, IRQ_VEC unused.
// TESTING
//  1 reset with pc=8'h37 -> next cycle pc=0, stickies 0; 3 NOPs -> pc=1,2,3.
//  2 pc=8'hFF, instr=ADD -> pc=8'h00, taken=0 (wrap).
//  3 BRF sel=0 val=1 target=8'h40, flags=8'h21 -> pc=8'h40, taken=1;
//    same with flags=8'h20 -> pc+1, taken=0; sel=6 -> never taken.
//  4 CALL x5 from pc=10 (DEPTH=4) -> 5th sets stack_ovf, pc=target; RET x4
//    returns in LIFO order; 5th RET -> stack_unf=1, pc+1.
//  5 en=0 with JMP target=8'h55 -> pc held, taken=0; reset mid-stall -> pc=0.
//  6 BPU_IRQ_EN, pc=8'h20, irq=1, flags=8'h30, instr=JMP -> pc=8'hF0,
//    irq_ack=1; RET -> pc=8'h20. Without macro: JMP executes, irq_ack=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program counter / branch stage: conditional branch on flag word, JMP, CALL/RET
// with a small return-address stack. Optional interrupt vectoring under BPU_IRQ_EN.
module branch_pc_unit #(
    parameter int                 ADDR_W      = 8,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [ADDR_W-1:0]  IRQ_VEC     = ADDR_W'(8'hF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [4:0]        instr,
    input  logic [2:0]        sel,
    input  logic              val,
    input  logic [ADDR_W-1:0] target,
    input  logic [7:0]        flags,
    input  logic              irq,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              irq_ack
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [4:0] OP_BRF  = 5'h1B;
    localparam logic [4:0] OP_JMP  = 5'h1C;
    localparam logic [4:0] OP_CALL = 5'h1D;
    localparam logic [4:0] OP_RET  = 5'h1E;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              taken_q, taken_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ack_q, ack_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pop_val;
    logic [ADDR_W-1:0] push_val;
    logic              push;
    logic              irq_take;
    logic              stack_full;
    logic              stack_empty;

`ifdef BPU_IRQ_EN
    assign irq_take = en & irq & flags[4];
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_take   = 1'b0;
`endif

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Top-of-stack entry sits at index sp_q-1.
    always_comb begin
        pop_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) pop_val = stack_q[i];
        end
    end

    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        taken_d  = 1'b0;
        ack_d    = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        push_val = pc_inc;
        if (en) begin
            if (irq_take) begin
                // The skipped instruction re-executes after RET.
                push     = 1'b1;
                push_val = pc_q;
                pc_d     = IRQ_VEC;
                taken_d  = 1'b1;
                ack_d    = 1'b1;
            end else begin
                unique case (instr)
                    OP_BRF: begin
                        if (sel <= 3'd5 && flags[sel] == val) begin
                            pc_d    = target;
                            taken_d = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                    OP_JMP: begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                    OP_CALL: begin
                        push    = 1'b1;
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            unf_d = 1'b1;
                            pc_d  = pc_inc;
                        end else begin
                            pc_d    = pop_val;
                            sp_d    = sp_q - SP_W'(1);
                            taken_d = 1'b1;
                        end
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            if (push) begin
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SP_W'(i)) stack_d[i] = push_val;
                    end
                    sp_d = sp_q + SP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ack_q   <= ack_d;
        end
    end

    // Entries above the pointer are don't-care, so the array needs no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
    assign irq_ack   = ack_q;

endmodule
